// File: rtl/dd_puf_pkg.sv
// Shared types and helpers for the DD-PUF response controller.
package dd_puf_pkg;

    localparam int PUF_W = 128;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        RACE    = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } state_e;

    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/dd_puf_vote_acc.sv
// One-bit vote accumulator: counts captures where the synchronized PUF bit was 1.
module dd_puf_vote_acc
    import dd_puf_pkg::*;
#(
    parameter int NUM_EVAL = 5
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_inc,
    input  logic i_bit,
    output logic o_major,
    output logic o_unanimous
);
    localparam int CW = cnt_width(NUM_EVAL);

    logic [CW-1:0] r_votes;
    logic [CW-1:0] w_votes_nxt;

    always_comb begin
        w_votes_nxt = r_votes;
        if (i_clear) begin
            w_votes_nxt = '0;
        end else if (i_inc && i_bit) begin
            w_votes_nxt = r_votes + CW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_votes <= '0;
        end else begin
            r_votes <= w_votes_nxt;
        end
    end

    // Decisions use the post-capture count so the top can register them on DONE entry.
    assign o_major     = (w_votes_nxt > CW'(NUM_EVAL / 2));
    assign o_unanimous = (w_votes_nxt == '0) || (w_votes_nxt == CW'(NUM_EVAL));

endmodule

// File: rtl/dd_puf_ctrl.sv
// DD-PUF sequencer: repeated reset/race/capture evaluations, majority vote and stability mask.
// state   | meaning
// IDLE    | array held in reset, waiting for REQ
// CLEAR   | array held in reset for RST_CYC cycles
// RACE    | START high for SETTLE_CYC cycles while the delay lines race
// CAPTURE | START still high; synchronized response counted into the votes
// DONE    | RESP/STABLE valid, waiting for ACK
module dd_puf_ctrl
    import dd_puf_pkg::*;
#(
    parameter int NUM_EVAL   = 5,
    parameter int RST_CYC    = 4,
    parameter int SETTLE_CYC = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             REQ,
    input  logic             ABORT,
    input  logic             ACK,
    input  logic [PUF_W-1:0] PUF_RESP,
    output logic             PUF_RESET,
    output logic             PUF_START,
    output logic [PUF_W-1:0] RESP,
    output logic [PUF_W-1:0] STABLE,
    output logic             VALID,
    output logic             BUSY
);
    localparam int CW   = cnt_width(NUM_EVAL);
    localparam int TMAX = (RST_CYC > SETTLE_CYC) ? RST_CYC : SETTLE_CYC;
    localparam int TW   = cnt_width(TMAX);
    localparam logic [TW-1:0] TMR_RST   = TW'(RST_CYC - 1);
    localparam logic [TW-1:0] TMR_SET   = TW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] EVAL_LAST = CW'(NUM_EVAL - 1);

    state_e           r_state, w_state_nxt;
    logic [TW-1:0]    r_tmr, w_tmr_nxt;
    logic [CW-1:0]    r_eval, w_eval_nxt;
    logic [PUF_W-1:0] r_sync1, r_sync2;
    logic [PUF_W-1:0] w_major, w_unan;
    logic [PUF_W-1:0] r_resp, r_stable;
    logic             w_clear, w_cap, w_done_load;
    logic             w_racing;
    logic             r_puf_reset, r_puf_start, r_valid, r_busy;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= PUF_RESP;
            r_sync2 <= r_sync1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tmr_nxt   = r_tmr;
        w_eval_nxt  = r_eval;
        w_clear     = 1'b0;
        w_cap       = 1'b0;
        w_done_load = 1'b0;
        case (r_state)
            IDLE: begin
                if (REQ) begin
                    w_state_nxt = CLEAR;
                    w_tmr_nxt   = TMR_RST;
                    w_eval_nxt  = '0;
                    w_clear     = 1'b1;
                end
            end
            CLEAR: begin
                if (ABORT) begin
                    w_state_nxt = IDLE;
                end else if (r_tmr == '0) begin
                    w_state_nxt = RACE;
                    w_tmr_nxt   = TMR_SET;
                end else begin
                    w_tmr_nxt = r_tmr - TW'(1);
                end
            end
            RACE: begin
                if (ABORT) begin
                    w_state_nxt = IDLE;
                end else if (r_tmr == '0) begin
                    w_state_nxt = CAPTURE;
                end else begin
                    w_tmr_nxt = r_tmr - TW'(1);
                end
            end
            CAPTURE: begin
                if (ABORT) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cap      = 1'b1;
                    w_eval_nxt = r_eval + CW'(1);
                    if (r_eval == EVAL_LAST) begin
                        w_state_nxt = DONE;
                        w_done_load = 1'b1;
                    end else begin
                        w_state_nxt = CLEAR;
                        w_tmr_nxt   = TMR_RST;
                    end
                end
            end
            DONE: begin
                if (ACK) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_racing = (w_state_nxt == RACE) || (w_state_nxt == CAPTURE);

    // Array controls are registered from the next state so they change only on clock edges.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= IDLE;
            r_tmr       <= '0;
            r_eval      <= '0;
            r_puf_reset <= 1'b1;
            r_puf_start <= 1'b0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_resp      <= '0;
            r_stable    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_tmr       <= w_tmr_nxt;
            r_eval      <= w_eval_nxt;
            r_puf_reset <= !w_racing;
            r_puf_start <= w_racing;
            r_valid     <= (w_state_nxt == DONE);
            r_busy      <= (w_state_nxt != IDLE);
            if (w_done_load) begin
                r_resp   <= w_major;
                r_stable <= w_unan;
            end
        end
    end

    for (genvar gi = 0; gi < PUF_W; gi++) begin : g_acc
        dd_puf_vote_acc #(.NUM_EVAL(NUM_EVAL)) u_acc (
            .i_clk       (CLK),
            .i_rst       (RESET),
            .i_clear     (w_clear),
            .i_inc       (w_cap),
            .i_bit       (r_sync2[gi]),
            .o_major     (w_major[gi]),
            .o_unanimous (w_unan[gi])
        );
    end

    assign PUF_RESET = r_puf_reset;
    assign PUF_START = r_puf_start;
    assign RESP      = r_resp;
    assign STABLE    = r_stable;
    assign VALID     = r_valid;
    assign BUSY      = r_busy;

endmodule

// File: tb/tb_dd_puf_ctrl.sv
// Bench for dd_puf_ctrl: a 5-evaluation instance and a single-evaluation instance.
module tb_dd_puf_ctrl;
    localparam int R = 4;
    localparam int S = 8;
    localparam int P = R + S + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         req  [2];
    logic         abrt [2];
    logic         ack  [2];
    logic [127:0] pin  [2];
    logic         pr   [2];
    logic         ps   [2];
    logic         vl   [2];
    logic         by   [2];
    logic [127:0] rs   [2];
    logic [127:0] st   [2];

    int           n_vec = 0;
    int           n_bad = 0;
    logic [127:0] pats [5];

    dd_puf_ctrl #(.NUM_EVAL(5), .RST_CYC(R), .SETTLE_CYC(S)) u_dut (
        .CLK(clk), .RESET(rst), .REQ(req[0]), .ABORT(abrt[0]), .ACK(ack[0]),
        .PUF_RESP(pin[0]), .PUF_RESET(pr[0]), .PUF_START(ps[0]),
        .RESP(rs[0]), .STABLE(st[0]), .VALID(vl[0]), .BUSY(by[0])
    );

    dd_puf_ctrl #(.NUM_EVAL(1), .RST_CYC(R), .SETTLE_CYC(S)) u_dut1 (
        .CLK(clk), .RESET(rst), .REQ(req[1]), .ABORT(abrt[1]), .ACK(ack[1]),
        .PUF_RESP(pin[1]), .PUF_RESET(pr[1]), .PUF_START(ps[1]),
        .RESP(rs[1]), .STABLE(st[1]), .VALID(vl[1]), .BUSY(by[1])
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Reference: count ones per bit over the evaluations actually performed.
    task automatic model(input int ne, output logic [127:0] r, output logic [127:0] s);
        for (int i = 0; i < 128; i++) begin
            int v;
            v = 0;
            for (int k = 0; k < ne; k++) v += int'(pats[k][i]);
            r[i] = (2 * v > ne);
            s[i] = (v == 0) || (v == ne);
        end
    endtask

    task automatic gen_pats();
        logic [127:0] base;
        base = rnd128();
        for (int k = 0; k < 5; k++) pats[k] = base ^ (rnd128() & rnd128() & rnd128());
    endtask

    task automatic chk_rst(input int d);
        chk("rst_puf_reset", 128'(pr[d]), 128'd1);
        chk("rst_puf_start", 128'(ps[d]), 128'd0);
        chk("rst_resp",      rs[d],       128'd0);
        chk("rst_stable",    st[d],       128'd0);
        chk("rst_valid",     128'(vl[d]), 128'd0);
        chk("rst_busy",      128'(by[d]), 128'd0);
    endtask

    task automatic run_resp(input int d, input int ne, input bit hold_req, input int ack_delay);
        int           n;
        int           drops;
        bit           seen;
        logic [127:0] r_exp, s_exp;
        model(ne, r_exp, s_exp);
        req[d] = 1'b1;
        n      = 0;
        seen   = 1'b0;
        while (!seen && n < 300) begin
            step();
            n++;
            if (!hold_req) req[d] = 1'b0;
            if (n == 6) begin
                chk("race_start", 128'(ps[d]), 128'd1);
                chk("race_reset", 128'(pr[d]), 128'd0);
            end
            if (vl[d]) seen = 1'b1;
            else if ((n % P) == 1 && (n / P) < ne) pin[d] = pats[n / P];
        end
        chk("latency", 128'(n), 128'(1 + ne * P));
        chk("resp",    rs[d], r_exp);
        chk("stable",  st[d], s_exp);
        chk("done_puf_reset", 128'(pr[d]), 128'd1);
        chk("done_puf_start", 128'(ps[d]), 128'd0);
        chk("done_busy",      128'(by[d]), 128'd1);
        drops = 0;
        abrt[d] = 1'b1;
        for (int c = 0; c < ack_delay; c++) begin
            step();
            if (!vl[d] || rs[d] !== r_exp || st[d] !== s_exp) drops++;
        end
        abrt[d] = 1'b0;
        chk("done_hold", 128'(drops), 128'd0);
        ack[d] = 1'b1;
        step();
        ack[d] = 1'b0;
        chk("ack_valid",  128'(vl[d]), 128'd0);
        chk("ack_busy",   128'(by[d]), 128'd0);
        chk("ack_resp",   rs[d], r_exp);
        chk("ack_stable", st[d], s_exp);
        step();
        chk("after_ack_busy", 128'(by[d]), 128'(hold_req));
        if (hold_req) chk("after_ack_clear", 128'(pr[d]), 128'd1);
    endtask

    initial begin
        int           n;
        int           vbad;
        logic [127:0] resp_before;

        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req[d] = 1'b0; abrt[d] = 1'b0; ack[d] = 1'b0; pin[d] = '0;
        end
        step();
        step();
        chk_rst(0);
        chk_rst(1);
        rst = 1'b0;
        abrt[0] = 1'b1;
        step();
        abrt[0] = 1'b0;
        chk("idle_abort_busy", 128'(by[0]), 128'd0);

        for (int k = 0; k < 5; k++) pats[k] = {16{8'hA5}};
        run_resp(0, 5, 1'b0, 2);

        pats[0] = 128'd1; pats[1] = 128'd1; pats[2] = 128'd0; pats[3] = 128'd1; pats[4] = 128'd0;
        run_resp(0, 5, 1'b0, 1);

        for (int t = 0; t < 3; t++) begin
            gen_pats();
            run_resp(0, 5, 1'b0, int'($urandom_range(0, 4)));
        end

        gen_pats();
        run_resp(0, 5, 1'b1, 10);
        req[0] = 1'b0;
        abrt[0] = 1'b1;
        step();
        abrt[0] = 1'b0;
        chk("clear_abort_busy", 128'(by[0]), 128'd0);

        // Abort in the third cycle of the second race.
        resp_before = rs[0];
        gen_pats();
        pin[0] = pats[0];
        req[0] = 1'b1;
        n = 0;
        while (n < 20) begin
            step();
            n++;
            req[0] = 1'b0;
        end
        chk("race2_start", 128'(ps[0]), 128'd1);
        abrt[0] = 1'b1;
        step();
        abrt[0] = 1'b0;
        chk("abort_busy",      128'(by[0]), 128'd0);
        chk("abort_puf_reset", 128'(pr[0]), 128'd1);
        chk("abort_puf_start", 128'(ps[0]), 128'd0);
        chk("abort_resp",      rs[0], resp_before);
        vbad = 0;
        for (int c = 0; c < 80; c++) begin
            step();
            if (vl[0] || by[0]) vbad++;
        end
        chk("abort_no_valid", 128'(vbad), 128'd0);

        // Reset while in the first capture cycle.
        req[0] = 1'b1;
        n = 0;
        while (n < 13) begin
            step();
            n++;
            req[0] = 1'b0;
        end
        chk("cap_start", 128'(ps[0]), 128'd1);
        rst = 1'b1;
        step();
        chk_rst(0);
        rst = 1'b0;
        step();

        pats[0] = rnd128();
        run_resp(1, 1, 1'b0, 3);
        gen_pats();
        run_resp(1, 1, 1'b0, 0);

        gen_pats();
        run_resp(0, 5, 1'b0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
